// File: rtl/depth_line_streamer_pkg.sv
// depth_stream_pkg: shared types and constants for the depth line streamer.
//   - width_of(): address/counter width helper that never returns 0.
//   - X_W / Y_W:  coordinate widths for the default 640x480 geometry.
//   - writer_state_t / reader_state_t: FSM encodings.
//   - SOF_LINE:   line index whose x = 0 beat carries start-of-frame.
package depth_stream_pkg;

    // Width needed to count 0..n-1, with a floor of one bit so that
    // degenerate sizes (n <= 2) still give a legal vector.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_SCREEN_WIDTH  = 640;
    localparam int unsigned DEF_SCREEN_HEIGHT = 480;
    localparam int unsigned X_W = width_of(DEF_SCREEN_WIDTH);
    localparam int unsigned Y_W = width_of(DEF_SCREEN_HEIGHT);

    typedef enum logic [1:0] {
        W_START = 2'd0,
        W_FILL  = 2'd1,
        W_HOLD  = 2'd2
    } writer_state_t;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } reader_state_t;

    localparam int unsigned SOF_LINE = 0;

endpackage

// File: rtl/depth_line_streamer_ram.sv
// line_bank_ram: simple dual-port RAM holding both line banks.
// The bank select is the address MSB, x is the low part.
//   clk      : clock
//   wr_en    : synchronous write strobe
//   wr_addr  : {bank, x} write address
//   wr_data  : write data
//   rd_en    : read enable; rd_data only updates when set, so the read
//              register doubles as a holding stage while downstream stalls
//   rd_addr  : {bank, x} read address
//   rd_data  : registered read data (1-cycle latency)
module line_bank_ram #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/depth_line_streamer.sv
// depth_line_streamer: collects out-of-order (x, depth) writes from the
// per-line depth engine into a ping-pong line buffer, restarts the engine
// whenever a bank is free, and streams completed lines in raster order.
//   clk, reset : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_depth : engine write port
//   line_done  : engine line-complete level (rising edge ends a line)
//   eng_start  : engine start request, high START_HOLD cycles
//   m_tdata/m_tvalid/m_tready/m_tlast/m_tuser : output pixel stream
//   wr_err     : sticky flag, set when a write had to be dropped
module depth_line_streamer
    import depth_stream_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned DEPTH_WIDTH   = 10,
    parameter int unsigned START_HOLD    = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]  wr_addr,
    input  logic [DEPTH_WIDTH-1:0]           wr_depth,
    input  logic                             line_done,
    output logic                             eng_start,
    output logic [DEPTH_WIDTH-1:0]           m_tdata,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic                             m_tlast,
    output logic                             m_tuser,
    output logic                             wr_err
);

    localparam int unsigned ADDR_W = $clog2(SCREEN_WIDTH);
    localparam int unsigned LINE_W = width_of(SCREEN_HEIGHT);
    localparam int unsigned CNT_W  = width_of(START_HOLD + 1);

    // ------------------------------------------------------------------
    // Writer side
    // ------------------------------------------------------------------
    writer_state_t     w_state_reg;
    logic [CNT_W-1:0]  start_cnt_reg;
    logic              eng_start_reg;
    logic              fill_sel_reg;
    logic [LINE_W-1:0] line_cnt_reg;
    logic              wr_err_reg;
    logic              line_done_d_reg;

    logic              full_reg  [2];
    logic              full_set  [2];
    logic              full_clr  [2];
    logic [LINE_W-1:0] bank_line_reg [2];

    logic line_done_rise;
    logic fill_edge;
    logic addr_ok;
    logic wr_accept;
    logic wr_drop;
    logic other_sel;
    logic other_free;
    logic fill_free;

    // Reader-side signals needed by the writer
    logic last_xfer;
    logic rd_sel_reg;

    assign line_done_rise = line_done & ~line_done_d_reg;
    // Only an edge seen while filling closes a line; edges in other states
    // belong to lines we never asked for.
    assign fill_edge = (w_state_reg == W_FILL) && line_done_rise;
    assign addr_ok   = ({1'b0, wr_addr} < (ADDR_W + 1)'(SCREEN_WIDTH));
    assign wr_accept = wr_en && (w_state_reg == W_FILL) && addr_ok;
    assign wr_drop   = wr_en && !wr_accept;

    // Bank availability is judged on the post-clear value so a line end that
    // coincides with the reader releasing the other bank restarts at once.
    assign other_sel  = ~fill_sel_reg;
    assign other_free = !full_reg[other_sel] || full_clr[other_sel];
    assign fill_free  = !full_reg[fill_sel_reg] || full_clr[fill_sel_reg];

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign full_set[gi] = fill_edge && (fill_sel_reg == 1'(gi));
        assign full_clr[gi] = last_xfer && (rd_sel_reg == 1'(gi));

        always_ff @(posedge clk) begin
            if (reset) begin
                full_reg[gi] <= 1'b0;
            end else begin
                full_reg[gi] <= (full_reg[gi] & ~full_clr[gi]) | full_set[gi];
            end
        end

        // Line index travels with the bank so the reader knows which line
        // carries start-of-frame.
        always_ff @(posedge clk) begin
            if (reset) begin
                bank_line_reg[gi] <= '0;
            end else if (full_set[gi]) begin
                bank_line_reg[gi] <= line_cnt_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_reg     <= W_START;
            start_cnt_reg   <= '0;
            eng_start_reg   <= 1'b0;
            fill_sel_reg    <= 1'b0;
            line_cnt_reg    <= '0;
            wr_err_reg      <= 1'b0;
            line_done_d_reg <= 1'b0;
        end else begin
            line_done_d_reg <= line_done;
            eng_start_reg   <= 1'b0;
            if (wr_drop) begin
                wr_err_reg <= 1'b1;
            end
            case (w_state_reg)
                W_START: begin
                    if (start_cnt_reg == CNT_W'(START_HOLD)) begin
                        start_cnt_reg <= '0;
                        w_state_reg   <= W_FILL;
                    end else begin
                        eng_start_reg <= 1'b1;
                        start_cnt_reg <= start_cnt_reg + CNT_W'(1);
                    end
                end
                W_FILL: begin
                    if (line_done_rise) begin
                        fill_sel_reg <= other_sel;
                        line_cnt_reg <= (line_cnt_reg == LINE_W'(SCREEN_HEIGHT - 1))
                                        ? '0 : line_cnt_reg + LINE_W'(1);
                        w_state_reg  <= other_free ? W_START : W_HOLD;
                    end
                end
                W_HOLD: begin
                    if (fill_free) begin
                        w_state_reg <= W_START;
                    end
                end
                default: begin
                    w_state_reg <= W_START;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Reader side: RAM read register (stage 1) feeding the output register.
    // Stage 1 only advances when the output register can take its beat, so
    // the pair behaves as a two-entry skid and stays at full rate.
    // ------------------------------------------------------------------
    reader_state_t          r_state_reg;
    logic [ADDR_W-1:0]      x_rd_reg;
    logic                   issue_done_reg;
    logic                   s1_valid_reg;
    logic                   s1_last_reg;
    logic                   s1_user_reg;
    logic                   m_tvalid_reg;
    logic [DEPTH_WIDTH-1:0] m_tdata_reg;
    logic                   m_tlast_reg;
    logic                   m_tuser_reg;

    logic                   out_ready;
    logic                   s1_ready;
    logic                   rd_issue;
    logic [ADDR_W-1:0]      rd_x;
    logic [DEPTH_WIDTH-1:0] ram_rd_data;

    assign out_ready = !m_tvalid_reg || m_tready;
    assign s1_ready  = !s1_valid_reg || out_ready;
    // Idle issues x = 0 directly on seeing a full bank to keep the
    // inter-line gap at two cycles.
    assign rd_x      = (r_state_reg == R_IDLE) ? '0 : x_rd_reg;
    assign rd_issue  = s1_ready &&
                       (((r_state_reg == R_IDLE) && full_reg[rd_sel_reg]) ||
                        ((r_state_reg == R_STREAM) && !issue_done_reg));
    assign last_xfer = m_tvalid_reg && m_tready && m_tlast_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_reg    <= R_IDLE;
            rd_sel_reg     <= 1'b0;
            x_rd_reg       <= '0;
            issue_done_reg <= 1'b0;
            s1_valid_reg   <= 1'b0;
            s1_last_reg    <= 1'b0;
            s1_user_reg    <= 1'b0;
            m_tvalid_reg   <= 1'b0;
            m_tdata_reg    <= '0;
            m_tlast_reg    <= 1'b0;
            m_tuser_reg    <= 1'b0;
        end else begin
            if (rd_issue) begin
                s1_valid_reg   <= 1'b1;
                s1_last_reg    <= (rd_x == ADDR_W'(SCREEN_WIDTH - 1));
                s1_user_reg    <= (rd_x == '0) &&
                                  (bank_line_reg[rd_sel_reg] == LINE_W'(SOF_LINE));
                x_rd_reg       <= rd_x + ADDR_W'(1);
                issue_done_reg <= (rd_x == ADDR_W'(SCREEN_WIDTH - 1));
            end else if (out_ready) begin
                s1_valid_reg <= 1'b0;
            end

            if (out_ready) begin
                m_tvalid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    m_tdata_reg <= ram_rd_data;
                    m_tlast_reg <= s1_last_reg;
                    m_tuser_reg <= s1_user_reg;
                end
            end

            case (r_state_reg)
                R_IDLE: begin
                    if (rd_issue) begin
                        r_state_reg <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (last_xfer) begin
                        r_state_reg <= R_IDLE;
                        rd_sel_reg  <= ~rd_sel_reg;
                    end
                end
                default: begin
                    r_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    line_bank_ram #(
        .ADDR_W (ADDR_W + 1),
        .DATA_W (DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr ({fill_sel_reg, wr_addr}),
        .wr_data (wr_depth),
        .rd_en   (rd_issue),
        .rd_addr ({rd_sel_reg, rd_x}),
        .rd_data (ram_rd_data)
    );

    assign eng_start = eng_start_reg;
    assign m_tdata   = m_tdata_reg;
    assign m_tvalid  = m_tvalid_reg;
    assign m_tlast   = m_tlast_reg;
    assign m_tuser   = m_tuser_reg;
    assign wr_err    = wr_err_reg;

endmodule

// File: tb/tb_depth_line_streamer.sv
// Scoreboard bench for depth_line_streamer (W=8, H=2, START_HOLD=2).
// The engine model writes a line's depths in arbitrary order; the reference
// keeps the last value written per x and, at line end, queues the whole line
// in raster order. A separate monitor pops and compares on every transfer.
module tb_depth_line_streamer;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int DW = 10;
    localparam int SH = 2;
    localparam int XW = $clog2(W);

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [XW-1:0] wr_addr;
    logic [DW-1:0] wr_depth;
    logic          line_done;
    logic          eng_start;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          m_tuser;
    logic          wr_err;

    always #5 clk = ~clk;

    depth_line_streamer #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .DEPTH_WIDTH   (DW),
        .START_HOLD    (SH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_depth  (wr_depth),
        .line_done (line_done),
        .eng_start (eng_start),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .wr_err    (wr_err)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    beat_t         exp_q[$];
    int            checks     = 0;
    int            failures   = 0;
    int            ready_mode = 0;   // 0 always, 1 pattern 1,0,0,1, 2 random, 3 stalled
    int            beats_seen = 0;
    int            tlast_seen = 0;
    int            line_idx   = 0;
    logic [DW-1:0] ref_line [W];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Downstream ready generator
    int rphase = 0;
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: m_tready = 1'b1;
            1: begin
                m_tready = (rphase == 0) || (rphase == 3);
                rphase   = (rphase + 1) % 4;
            end
            2: m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    end

    // Monitor: pops on every transfer, and checks that a stalled beat holds.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          prev_user;
    always begin
        @(negedge clk);
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_tvalid", m_tvalid, 1);
                check("hold_tdata", m_tdata, prev_data);
                check("hold_tlast", m_tlast, prev_last);
                check("hold_tuser", m_tuser, prev_user);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got tdata=%0d, expected no beat", m_tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    $display("beat tdata=%0d tlast=%0d tuser=%0d (exp %0d %0d %0d)",
                             m_tdata, m_tlast, m_tuser, e.data, e.last, e.user);
                    check("beat_tdata", m_tdata, e.data);
                    check("beat_tlast", m_tlast, e.last);
                    check("beat_tuser", m_tuser, e.user);
                end
                beats_seen++;
                if (m_tlast) tlast_seen++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            prev_user  = m_tuser;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int x, input int d);
        wr_en    = 1'b1;
        wr_addr  = XW'(x);
        wr_depth = DW'(d);
        tick();
        wr_en    = 1'b0;
        $display("write x=%0d depth=%0d", x, d);
    endtask

    // Waits for an eng_start request and measures how long it stays high.
    task automatic wait_start(output int hi, output bit ok);
        hi = 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (eng_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            while (eng_start && hi < 20) begin
                hi++;
                @(negedge clk);
            end
        end
        $display("eng_start seen=%0d high_cycles=%0d", ok, hi);
    endtask

    task automatic start_check(input string name);
        int hi;
        bit ok;
        wait_start(hi, ok);
        check({name, "_seen"}, 32'(ok), 1);
        if (ok) check({name, "_len"}, hi, SH);
    endtask

    // One engine line: all x once in some order (optionally a few overwrites),
    // then a line_done rising edge; the reference line is queued at the edge.
    task automatic send_line(input bit fixed);
        int order [W];
        int fixed_order [W] = '{7, 3, 0, 5, 1, 6, 2, 4};
        for (int i = 0; i < W; i++) order[i] = fixed ? fixed_order[i] : i;
        if (!fixed) begin
            for (int i = W - 1; i > 0; i--) begin
                int j;
                int t;
                j = $urandom_range(0, i);
                t = order[i];
                order[i] = order[j];
                order[j] = t;
            end
        end
        for (int i = 0; i < W; i++) begin
            int d;
            d = fixed ? 10 + order[i] : int'($urandom_range(0, 1023));
            do_write(order[i], d);
            ref_line[order[i]] = DW'(d);
        end
        if (!fixed) begin
            repeat (3) begin
                int x;
                int d;
                x = $urandom_range(0, W - 1);
                d = $urandom_range(0, 1023);
                do_write(x, d);
                ref_line[x] = DW'(d);
            end
        end
        line_done = 1'b1;
        for (int x = 0; x < W; x++) begin
            beat_t b;
            b.data = ref_line[x];
            b.last = (x == W - 1);
            b.user = (x == 0) && (line_idx == 0);
            exp_q.push_back(b);
        end
        $display("line_done line_idx=%0d", line_idx);
        line_idx = (line_idx + 1) % H;
        tick();
        line_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_depth  = '0;
        line_done = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_eng_start", eng_start, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tuser", m_tuser, 0);
        check("rst_wr_err", wr_err, 0);

        // Reset release: eng_start high exactly on cycles 1 and 2
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("start_cycle%0d", c), eng_start, (c <= SH) ? 1 : 0);
            check($sformatf("idle_tvalid%0d", c), m_tvalid, 0);
        end

        // Line A: fixed out-of-order writes, ready held high
        send_line(1'b1);
        start_check("restart_a");
        wait_drain("drain_a");

        // Line B: random data, ready pattern 1,0,0,1
        ready_mode = 1;
        send_line(1'b0);
        start_check("restart_b");
        wait_drain("drain_b");

        // Lines C and D with the sink stalled: both banks fill, writer holds
        ready_mode = 3;
        send_line(1'b0);
        start_check("restart_c");
        send_line(1'b0);
        begin
            int hi = 0;
            repeat (20) begin
                @(negedge clk);
                if (eng_start) hi++;
            end
            check("hold_no_start", hi, 0);
        end
        do_write(2, 999);   // dropped: writer is holding
        @(negedge clk);
        check("wr_err_hold", wr_err, 1);
        begin
            int base;
            int hi;
            bit ok;
            base = tlast_seen;
            ready_mode = 0;
            wait_start(hi, ok);
            check("release_start_seen", 32'(ok), 1);
            check("start_after_first_tlast", tlast_seen, base + 1);
        end
        wait_drain("drain_cd");
        check("wr_err_sticky", wr_err, 1);

        // Line E: random data and random ready
        ready_mode = 2;
        send_line(1'b0);
        start_check("restart_e");
        wait_drain("drain_e");

        // Line F: reset after four beats
        ready_mode = 0;
        begin
            int base;
            bit reached;
            base    = beats_seen;
            reached = 1'b0;
            send_line(1'b0);
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (beats_seen - base >= 4) begin
                    reached = 1'b1;
                    break;
                end
            end
            check("reach_beat4", 32'(reached), 1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("tvalid_after_reset", m_tvalid, 0);
        check("wr_err_after_reset", wr_err, 0);
        tick();
        line_idx = 0;
        reset = 1'b0;
        start_check("start_after_reset");

        // Line G: new frame must open with tuser at x = 0
        send_line(1'b0);
        start_check("restart_g");
        wait_drain("drain_g");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
